// File: rtl/bootloader_test_top.sv
`default_nettype none
// ============================================================================
// Module      : bootloader_test_top (with submodule bootloader_uart)
// Description : UART packet bootloader test. While SW[0] (bootload_en) is
//               high, a 21-byte triangle packet is received on GPIO[5] into
//               a buffer. A rising SW[1] (transmit_en) with bootload_en low
//               and a valid packet echoes the buffer on GPIO[3].
// Ports       : FPGA_CLK1_50 - system clock
//               KEY[0]       - rst_n, asynchronous active-low (KEY[1] unused)
//               SW[0]        - bootload_en, SW[1] transmit_en (SW[3:2] unused)
//               LED[7:0]     - {cnt[4:0], tx busy, rx busy, triangle_valid}
//               GPIO[35:0]   - GPIO[5] UART RX, GPIO[3] UART TX, rest high-Z
// Option      : define BOOT_CHECKSUM_EN to require and append a trailing
//               XOR checksum byte (XOR of bytes 0..PKT_BYTES-1).
// Revision    : 1.0 - initial release
// ============================================================================

module bootloader_uart #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic       o_tx,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       tx_busy,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy,
    output logic [7:0] rx_data
);
    localparam int          c_BIT       = CLK_HZ / BAUD;
    localparam logic [15:0] c_BIT_LAST  = 16'(c_BIT - 1);
    localparam logic [15:0] c_HALF_LAST = 16'((c_BIT / 2) - 1);

    localparam logic [1:0] c_RX_IDLE  = 2'd0;
    localparam logic [1:0] c_RX_START = 2'd1;
    localparam logic [1:0] c_RX_DATA  = 2'd2;
    localparam logic [1:0] c_RX_STOP  = 2'd3;

    localparam logic c_TX_IDLE = 1'b0;
    localparam logic c_TX_SEND = 1'b1;

    // [0],[1] form the synchronizer; [2] is history for falling-edge detect
    logic [2:0]  r_rx_sync;
    logic [1:0]  r_rx_state;
    logic [15:0] r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_sr;
    logic        w_rx;
    logic        w_rx_fall;

    assign w_rx      = r_rx_sync[1];
    assign w_rx_fall = r_rx_sync[2] & ~r_rx_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sync  <= 3'b111;
            r_rx_state <= c_RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_sr    <= '0;
            rx_rdy     <= 1'b0;
            rx_data    <= '0;
        end else begin
            r_rx_sync <= {r_rx_sync[1:0], i_rx};
            if (clr_rx_rdy)
                rx_rdy <= 1'b0;
            case (r_rx_state)
                c_RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_state <= c_RX_START;
                        r_rx_cnt   <= '0;
                    end
                end
                c_RX_START: begin
                    // Mid start bit: a high line means a glitch, not a frame
                    if (r_rx_cnt == c_HALF_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= w_rx ? c_RX_IDLE : c_RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                c_RX_DATA: begin
                    if (r_rx_cnt == c_BIT_LAST) begin
                        r_rx_cnt <= '0;
                        r_rx_sr  <= {w_rx, r_rx_sr[7:1]};
                        r_rx_bit <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7)
                            r_rx_state <= c_RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                default: begin
                    // Stop bit: only a high stop bit delivers the byte
                    if (r_rx_cnt == c_BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= c_RX_IDLE;
                        if (w_rx) begin
                            rx_data <= r_rx_sr;
                            rx_rdy  <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    // Transmit shift register {stop, data, start}; shifting in ones keeps
    // the line high once the frame has been sent.
    logic        r_tx_state;
    logic [9:0]  r_tx_sr;
    logic [15:0] r_tx_cnt;
    logic [3:0]  r_tx_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= c_TX_IDLE;
            r_tx_sr    <= '1;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (r_tx_state == c_TX_IDLE) begin
                if (trmt) begin
                    r_tx_sr    <= {1'b1, tx_data, 1'b0};
                    r_tx_cnt   <= '0;
                    r_tx_bit   <= '0;
                    r_tx_state <= c_TX_SEND;
                end
            end else if (r_tx_cnt == c_BIT_LAST) begin
                r_tx_cnt <= '0;
                if (r_tx_bit == 4'd9) begin
                    r_tx_state <= c_TX_IDLE;
                    tx_done    <= 1'b1;
                end else begin
                    r_tx_bit <= r_tx_bit + 4'd1;
                    r_tx_sr  <= {1'b1, r_tx_sr[9:1]};
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 16'd1;
            end
        end
    end

    assign o_tx    = r_tx_sr[0];
    assign tx_busy = (r_tx_state == c_TX_SEND);

endmodule

module bootloader_test_top #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int PKT_BYTES = 21
) (
    input  logic        FPGA_CLK1_50,
    input  logic [1:0]  KEY,
    input  logic [3:0]  SW,
    output logic [7:0]  LED,
    inout  wire  [35:0] GPIO
);
    localparam logic [7:0] c_OPCODE = 8'h01;
    localparam logic [4:0] c_LAST   = 5'(PKT_BYTES - 1);
`ifdef BOOT_CHECKSUM_EN
    localparam logic [4:0] c_TX_LAST = 5'(PKT_BYTES);
`else
    localparam logic [4:0] c_TX_LAST = 5'(PKT_BYTES - 1);
`endif

    logic       w_clk;
    logic       w_rst_n;
    logic       w_tx;
    logic       w_tx_done;
    logic       w_tx_busy;
    logic       w_rx_rdy;
    logic [7:0] w_rx_data;
    logic [7:0] w_tx_data;
    logic       w_take;
    logic       w_boot;
    logic       w_ten;
    logic       w_unused;

    logic [1:0] r_sw_meta;
    logic [1:0] r_sw_sync;
    logic       r_ten_d;
    logic       r_clr_rx_rdy;
    logic [4:0] r_cnt;
    logic       r_triangle_valid;
    logic [7:0] r_rx_xor;
    logic [7:0] r_buf [0:PKT_BYTES-1];
    logic       r_tx_active;
    logic [4:0] r_tx_idx;
    logic       r_trmt;
    logic [7:0] r_tx_xor;

    assign w_clk    = FPGA_CLK1_50;
    assign w_rst_n  = KEY[0];
    assign w_boot   = r_sw_sync[0];
    assign w_ten    = r_sw_sync[1];
    assign w_unused = &{1'b0, KEY[1], SW[3:2], GPIO[35:6], GPIO[4:0]};

    assign GPIO[3]    = w_tx;
    assign GPIO[2:0]  = 3'bzzz;
    assign GPIO[4]    = 1'bz;
    assign GPIO[35:6] = {30{1'bz}};

    bootloader_uart #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_uart (
        .clk        (w_clk),
        .rst_n      (w_rst_n),
        .i_rx       (GPIO[5]),
        .o_tx       (w_tx),
        .trmt       (r_trmt),
        .tx_data    (w_tx_data),
        .tx_done    (w_tx_done),
        .tx_busy    (w_tx_busy),
        .rx_rdy     (w_rx_rdy),
        .clr_rx_rdy (r_clr_rx_rdy),
        .rx_data    (w_rx_data)
    );

    // rx_rdy stays high until the cycle after the clear, so a byte is
    // taken only on the first cycle it is seen.
    assign w_take = w_rx_rdy & ~r_clr_rx_rdy;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sw_meta        <= '0;
            r_sw_sync        <= '0;
            r_clr_rx_rdy     <= 1'b0;
            r_cnt            <= '0;
            r_triangle_valid <= 1'b0;
            r_rx_xor         <= '0;
            for (int i = 0; i < PKT_BYTES; i++)
                r_buf[i] <= '0;
        end else begin
            r_sw_meta    <= SW[1:0];
            r_sw_sync    <= r_sw_meta;
            r_clr_rx_rdy <= w_take;
            if (!w_boot) begin
                // Leaving bootload mid-packet abandons the count only
                r_cnt <= '0;
            end else if (w_take) begin
                if (r_cnt == 5'd0) begin
                    if (w_rx_data == c_OPCODE) begin
                        r_buf[0]         <= w_rx_data;
                        r_rx_xor         <= w_rx_data;
                        r_cnt            <= 5'd1;
                        r_triangle_valid <= 1'b0;
                    end
                end else if (r_cnt <= c_LAST) begin
                    r_buf[r_cnt] <= w_rx_data;
                    r_rx_xor     <= r_rx_xor ^ w_rx_data;
                    if (r_cnt == c_LAST) begin
`ifdef BOOT_CHECKSUM_EN
                        r_cnt <= r_cnt + 5'd1;
`else
                        r_cnt            <= '0;
                        r_triangle_valid <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end else begin
                    // Trailing checksum byte
                    r_cnt            <= '0;
                    r_triangle_valid <= (w_rx_data == r_rx_xor);
                end
            end
        end
    end

    always_comb begin
        w_tx_data = r_tx_xor;
        if (r_tx_idx <= c_LAST)
            w_tx_data = r_buf[r_tx_idx];
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ten_d     <= 1'b0;
            r_tx_active <= 1'b0;
            r_tx_idx    <= '0;
            r_trmt      <= 1'b0;
            r_tx_xor    <= '0;
        end else begin
            r_ten_d <= w_ten;
            r_trmt  <= 1'b0;
            if (!r_tx_active) begin
                if (w_ten && !r_ten_d && !w_boot && r_triangle_valid) begin
                    r_tx_active <= 1'b1;
                    r_tx_idx    <= '0;
                    r_trmt      <= 1'b1;
                    r_tx_xor    <= '0;
                end
            end else begin
                if (r_trmt)
                    r_tx_xor <= r_tx_xor ^ w_tx_data;
                if (w_tx_done) begin
                    // Bootload takes priority: stop after the byte just sent
                    if (w_boot || r_tx_idx == c_TX_LAST) begin
                        r_tx_active <= 1'b0;
                    end else begin
                        r_tx_idx <= r_tx_idx + 5'd1;
                        r_trmt   <= 1'b1;
                    end
                end
            end
        end
    end

    assign LED = {r_cnt, r_tx_active, (r_cnt != 5'd0), r_triangle_valid};

endmodule

`default_nettype wire

// File: tb/tb_bootloader_test_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_bootloader_test_top
// Description : Self-checking bench for bootloader_test_top. Drives UART
//               frames on GPIO[5], decodes frames from GPIO[3], and compares
//               LED state and echoed bytes with a packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bootloader_test_top;
    // Fast baud keeps the run short: 16 clocks per bit
    localparam int c_CLK_HZ = 50_000_000;
    localparam int c_BAUD   = 3_125_000;
    localparam int c_BIT    = c_CLK_HZ / c_BAUD;
    localparam int c_PKT    = 21;

    logic        clk = 1'b0;
    logic [1:0]  key;
    logic [3:0]  sw;
    logic        rx_line;
    logic [7:0]  led;
    wire  [35:0] gpio;

    assign gpio[5] = rx_line;

    always #10 clk = ~clk;

    bootloader_test_top #(
        .CLK_HZ    (c_CLK_HZ),
        .BAUD      (c_BAUD),
        .PKT_BYTES (c_PKT)
    ) dut (
        .FPGA_CLK1_50 (clk),
        .KEY          (key),
        .SW           (sw),
        .LED          (led),
        .GPIO         (gpio)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: packet contents, byte count, packet-valid flag
    logic [7:0] m_buf [0:c_PKT-1];
    int         m_cnt;
    bit         m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void model_byte(input logic [7:0] b);
        if (m_cnt == 0) begin
            if (b == 8'h01) begin
                m_buf[0] = b;
                m_cnt    = 1;
                m_valid  = 1'b0;
            end
        end else begin
            m_buf[m_cnt] = b;
            m_cnt++;
            if (m_cnt == c_PKT) begin
                m_cnt   = 0;
                m_valid = 1'b1;
            end
        end
    endfunction

    function automatic logic [7:0] exp_led();
        return {5'(m_cnt), 1'b0, (m_cnt != 0), m_valid};
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx_line = 1'b0;
        repeat (c_BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (c_BIT) @(negedge clk);
        end
        rx_line = stop_ok;
        repeat (c_BIT) @(negedge clk);
        rx_line = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_and_check(input logic [7:0] b);
        send_byte(b, 1'b1);
        model_byte(b);
        chk("rx_led", 32'(led), 32'(exp_led()));
    endtask

    task automatic get_frame(output logic [7:0] b, output bit ok);
        bit seen;
        b    = '0;
        ok   = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 40 * c_BIT; t++) begin
            @(negedge clk);
            if (gpio[3] === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) return;
        repeat (c_BIT / 2) @(negedge clk);
        if (gpio[3] !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (c_BIT) @(negedge clk);
            b[i] = gpio[3];
        end
        repeat (c_BIT) @(negedge clk);
        ok = (gpio[3] === 1'b1);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        bit low;
        low = 1'b0;
        for (int t = 0; t < cycles; t++) begin
            @(negedge clk);
            if (gpio[3] !== 1'b1) low = 1'b1;
        end
        chk(tag, 32'(low), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        bit         ok;
        bit         got;

        key     = 2'b10;
        sw      = 4'b0000;
        rx_line = 1'b1;
        m_cnt   = 0;
        m_valid = 1'b0;
        for (int i = 0; i < c_PKT; i++) m_buf[i] = 8'h00;

        repeat (5) @(negedge clk);
        chk("reset_led", 32'(led), 32'h00);
        chk("reset_tx", 32'(gpio[3]), 32'd1);
        key = 2'b11;
        repeat (5) @(negedge clk);
        chk("idle_led", 32'(led), 32'h00);
        chk("idle_tx", 32'(gpio[3]), 32'd1);

        // transmit_en edge with no valid packet must be ignored
        sw[1] = 1'b1;
        expect_quiet("tx_without_valid", 30 * c_BIT);
        chk("tx_without_valid_led", 32'(led), 32'h00);
        sw[1] = 1'b0;

        // Wrong opcode followed by 20 non-opcode bytes
        sw[0] = 1'b1;
        repeat (5) @(negedge clk);
        send_and_check(8'h02);
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            if (b == 8'h01) b = 8'h5a;
            send_and_check(b);
        end

        // Opcode with a low stop bit is discarded
        send_byte(8'h01, 1'b0);
        chk("bad_stop_led", 32'(led), 32'(exp_led()));

        // Fixed packet 01 00 00 25..36
        for (int i = 0; i < c_PKT - 1; i++) begin
            b = (i == 0) ? 8'h01 : (i < 3) ? 8'h00 : 8'(8'h22 + i);
            send_and_check(b);
        end
        got = 1'b0;
        fork
            send_byte(8'h36, 1'b1);
            begin
                for (int t = 0; t < 12 * c_BIT; t++) begin
                    @(negedge clk);
                    if (dut.u_uart.rx_rdy === 1'b1) begin
                        got = 1'b1;
                        break;
                    end
                end
                chk("last_rx_rdy_seen", 32'(got), 32'd1);
                chk("valid_at_rx_rdy", 32'(led[0]), 32'd0);
                @(negedge clk);
                chk("valid_after_rx_rdy", 32'(led[0]), 32'd1);
            end
        join
        model_byte(8'h36);
        chk("pkt1_led", 32'(led), 32'(exp_led()));
        chk("pkt1_buf3", 32'(dut.r_buf[3]), 32'h25);
        chk("pkt1_buf20", 32'(dut.r_buf[20]), 32'h36);

        // Echo: exactly 21 frames matching the packet
        sw[0] = 1'b0;
        repeat (5) @(negedge clk);
        sw[1] = 1'b1;
        for (int k = 0; k < c_PKT; k++) begin
            get_frame(b, ok);
            chk("tx1_frame_ok", 32'(ok), 32'd1);
            chk("tx1_byte", 32'(b), 32'(m_buf[k]));
            if (k == 0) chk("tx1_busy_led", 32'(led[2]), 32'd1);
        end
        expect_quiet("tx1_no_extra", 30 * c_BIT);
        chk("tx1_done_led", 32'(led), 32'(exp_led()));
        sw[1] = 1'b0;

        // transmit_en edge while bootloading is ignored
        sw[0] = 1'b1;
        repeat (5) @(negedge clk);
        sw[1] = 1'b1;
        expect_quiet("tx_during_boot", 30 * c_BIT);
        sw[1] = 1'b0;

        // Partial packet, bootload dropped, then a full random packet
        send_and_check(8'h01);
        for (int i = 0; i < 9; i++) send_and_check(8'($urandom));
        sw[0] = 1'b0;
        repeat (5) @(negedge clk);
        m_cnt = 0;
        chk("boot_drop_led", 32'(led), 32'(exp_led()));
        sw[0] = 1'b1;
        repeat (5) @(negedge clk);
        send_and_check(8'h01);
        for (int i = 1; i < c_PKT; i++) send_and_check(8'($urandom));

        // Echo of the random packet, aborted by bootload after three bytes
        sw[0] = 1'b0;
        repeat (5) @(negedge clk);
        sw[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            get_frame(b, ok);
            chk("tx2_frame_ok", 32'(ok), 32'd1);
            chk("tx2_byte", 32'(b), 32'(m_buf[k]));
        end
        sw[0] = 1'b1;
        expect_quiet("tx2_abort", 30 * c_BIT);
        chk("tx2_abort_led", 32'(led), 32'(exp_led()));
        sw[1] = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
